// File: rtl/csk_symbol_packer.sv
// csk_symbol_packer
//   Upstream feeder for the 6-bit M-sequence code-shift generator. Repacks a
//   valid/ready byte stream MSB-first into 6-bit shift codes, framing each packet
//   with PREAMBLE_LEN preamble symbols and sending IDLE_CODE between packets.
//
// Ports
//   clkin      : clock
//   rstn       : synchronous, active-low reset
//   s_data     : input byte, bit 7 sent first
//   s_valid    : s_data valid
//   s_last     : final byte of the frame
//   s_ready    : byte accepted on an edge with s_valid && s_ready
//   gen_ready  : generator consumes `code` on every edge where this is 1
//   code       : registered code to be transmitted next
//   busy       : frame in progress
//   underrun   : one-cycle pulse, a data symbol was due with fewer than 6 bits buffered
//   frame_done : one-cycle pulse, the last symbol of a frame has been consumed
module csk_symbol_packer #(
    parameter logic [5:0]  IDLE_CODE     = 6'd0,
    parameter logic [5:0]  PREAMBLE_CODE = 6'd62,
    parameter int unsigned PREAMBLE_LEN  = 4
) (
    input  logic       clkin,
    input  logic       rstn,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    input  logic       gen_ready,
    output logic [5:0] code,
    output logic       busy,
    output logic       underrun,
    output logic       frame_done
);

    typedef enum logic [1:0] {
        StIdle,
        StPreamble,
        StData
    } state_e;

    localparam logic [3:0] PreLen = 4'(PREAMBLE_LEN);

    state_e      state_q, state_d;
    logic [5:0]  code_q, code_d;
    logic [13:0] acc_q, acc_d;
    logic [3:0]  bitcnt_q, bitcnt_d;
    logic        last_seen_q, last_seen_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic        underrun_q, underrun_d;
    logic        frame_done_q, frame_done_d;

    logic        accept;
    logic        data_step;
    logic [13:0] acc_ext;
    logic [3:0]  cnt_ext;
    logic [5:0]  pad_mask;

    // Registers only: no combinational path from s_valid to s_ready.
    assign s_ready = (state_q != StIdle) && (bitcnt_q <= 4'd5) && !last_seen_q;
    assign accept  = s_valid && s_ready;

    // Keeps only the bitcnt valid bits at the top of the final short symbol.
    assign pad_mask = ~(6'h3F >> bitcnt_q);

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        last_seen_d  = last_seen_q;
        pre_cnt_d    = pre_cnt_q;
        underrun_d   = 1'b0;
        frame_done_d = 1'b0;
        data_step    = 1'b0;
        acc_ext      = acc_q;
        cnt_ext      = bitcnt_q;

        if (gen_ready) begin
            unique case (state_q)
                StIdle: begin
                    if (s_valid) begin
                        code_d    = PREAMBLE_CODE;
                        pre_cnt_d = 4'd1;
                        state_d   = StPreamble;
                    end else begin
                        code_d = IDLE_CODE;
                    end
                end
                StPreamble: begin
                    if (pre_cnt_q < PreLen) begin
                        code_d    = PREAMBLE_CODE;
                        pre_cnt_d = pre_cnt_q + 4'd1;
                    end else begin
                        state_d   = StData;
                        data_step = 1'b1;
                    end
                end
                StData: begin
                    data_step = 1'b1;
                end
                default: begin
                    state_d = StIdle;
                    code_d  = IDLE_CODE;
                end
            endcase
        end

        // Symbol extraction always works on the pre-accept accumulator.
        if (data_step) begin
            if (bitcnt_q >= 4'd6) begin
                code_d  = acc_q[13:8];
                acc_ext = acc_q << 6;
                cnt_ext = bitcnt_q - 4'd6;
            end else if (last_seen_q && (bitcnt_q != 4'd0)) begin
                code_d  = acc_q[13:8] & pad_mask;
                acc_ext = '0;
                cnt_ext = 4'd0;
            end else if (last_seen_q) begin
                code_d       = IDLE_CODE;
                frame_done_d = 1'b1;
                last_seen_d  = 1'b0;
                state_d      = StIdle;
            end else begin
                code_d     = IDLE_CODE;
                underrun_d = 1'b1;
            end
        end

        acc_d    = acc_ext;
        bitcnt_d = cnt_ext;
        if (accept) begin
            // Place the new byte directly below whatever bits remain after extraction.
            acc_d    = acc_ext | ({s_data, 6'b0} >> cnt_ext);
            bitcnt_d = cnt_ext + 4'd8;
            if (s_last) begin
                last_seen_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clkin) begin
        if (!rstn) begin
            state_q      <= StIdle;
            code_q       <= IDLE_CODE;
            acc_q        <= '0;
            bitcnt_q     <= '0;
            last_seen_q  <= 1'b0;
            pre_cnt_q    <= '0;
            underrun_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            acc_q        <= acc_d;
            bitcnt_q     <= bitcnt_d;
            last_seen_q  <= last_seen_d;
            pre_cnt_q    <= pre_cnt_d;
            underrun_q   <= underrun_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign code       = code_q;
    assign busy       = (state_q != StIdle);
    assign underrun   = underrun_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_csk_symbol_packer.sv
// tb_csk_symbol_packer
//   Drives csk_symbol_packer with directed and randomized byte frames and compares
//   every output on every cycle against a bit-queue reference model. Literal code
//   sequences for known frames pin both the DUT and the model.
module tb_csk_symbol_packer;

    localparam logic [5:0] IDLE_C  = 6'd0;
    localparam logic [5:0] PRE_C   = 6'd62;
    localparam int         PRE_LEN = 4;

    logic       clkin     = 1'b0;
    logic       rstn      = 1'b0;
    logic [7:0] s_data    = 8'h00;
    logic       s_valid   = 1'b0;
    logic       s_last    = 1'b0;
    logic       gen_ready = 1'b0;
    logic       s_ready;
    logic [5:0] code;
    logic       busy;
    logic       underrun;
    logic       frame_done;

    csk_symbol_packer #(
        .IDLE_CODE    (IDLE_C),
        .PREAMBLE_CODE(PRE_C),
        .PREAMBLE_LEN (PRE_LEN)
    ) dut (
        .clkin     (clkin),
        .rstn      (rstn),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .gen_ready (gen_ready),
        .code      (code),
        .busy      (busy),
        .underrun  (underrun),
        .frame_done(frame_done)
    );

    always #5 clkin = ~clkin;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: frame mode + queue of pending bits ----------
    int         m_mode = 0;     // 0 idle, 1 preamble, 2 data
    int         m_pre  = 0;
    bit         m_bits[$];
    bit         m_last = 1'b0;
    logic [5:0] m_code = IDLE_C;
    bit         m_under = 1'b0;
    bit         m_done  = 1'b0;

    function automatic bit m_ready();
        return (m_mode != 0) && (m_bits.size() <= 5) && !m_last;
    endfunction

    task automatic model_step();
        bit         acc_now;
        logic [5:0] c;
        m_under = 1'b0;
        m_done  = 1'b0;
        if (!rstn) begin
            m_mode = 0;
            m_pre  = 0;
            m_bits.delete();
            m_last = 1'b0;
            m_code = IDLE_C;
            return;
        end
        acc_now = s_valid && m_ready();
        if (gen_ready) begin
            if (m_mode == 0) begin
                if (s_valid) begin
                    m_code = PRE_C;
                    m_pre  = 1;
                    m_mode = 1;
                end else begin
                    m_code = IDLE_C;
                end
            end else if (m_mode == 1 && m_pre < PRE_LEN) begin
                m_code = PRE_C;
                m_pre++;
            end else begin
                m_mode = 2;
                if (m_bits.size() >= 6 || (m_last && m_bits.size() > 0)) begin
                    while (m_bits.size() < 6) m_bits.push_back(1'b0);
                    c = '0;
                    for (int i = 0; i < 6; i++) c = {c[4:0], m_bits.pop_front()};
                    m_code = c;
                end else if (m_last) begin
                    m_code = IDLE_C;
                    m_done = 1'b1;
                    m_last = 1'b0;
                    m_mode = 0;
                end else begin
                    m_code  = IDLE_C;
                    m_under = 1'b1;
                end
            end
        end
        if (acc_now) begin
            for (int i = 7; i >= 0; i--) m_bits.push_back(s_data[i]);
            if (s_last) m_last = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clkin);
        model_step();
    end

    // ---------------- per-cycle compare and consumed-code logging ----------------
    bit         cmp_en  = 1'b0;
    int         cons_cnt = 0;
    int         n_under  = 0;
    int         n_done   = 0;
    logic [5:0] dut_log[$];
    logic [5:0] mod_log[$];

    initial forever begin
        @(negedge clkin);
        if (cmp_en) begin
            check("code", 32'(code), 32'(m_code));
            check("s_ready", 32'(s_ready), 32'(m_ready()));
            check("busy", 32'(busy), 32'(m_mode != 0));
            check("underrun", 32'(underrun), 32'(m_under));
            check("frame_done", 32'(frame_done), 32'(m_done));
            if (underrun === 1'b1) n_under++;
            if (frame_done === 1'b1) n_done++;
            if (gen_ready) begin
                dut_log.push_back(code);
                mod_log.push_back(m_code);
                cons_cnt++;
            end
        end
    end

    // ---------------- generator model: 0 = every 63 clocks, 1 = always, 2 = random ---
    int gen_mode = 0;

    initial begin
        int gcnt = 0;
        forever begin
            @(posedge clkin);
            #1;
            gcnt++;
            case (gen_mode)
                0:       gen_ready = (gcnt % 63 == 0);
                1:       gen_ready = 1'b1;
                default: gen_ready = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input bit l);
        bit got = 1'b0;
        int n   = 0;
        s_valid = 1'b1;
        s_data  = b;
        s_last  = l;
        while (!got && n < 3000) begin
            @(negedge clkin);
            got = (s_ready === 1'b1);
            @(posedge clkin);
            #1;
            n++;
        end
        check("byte_accepted", 32'(got), 32'd1);
    endtask

    task automatic end_frame();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_consumes(input int n);
        int target = cons_cnt + n;
        int k      = 0;
        while (cons_cnt < target && k < 20000) begin
            @(posedge clkin);
            #1;
            k++;
        end
        check("consume_wait", 32'(cons_cnt >= target), 32'd1);
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (dut_log.size() < n && k < 20000) begin
            @(posedge clkin);
            #1;
            k++;
        end
        check("log_wait", 32'(dut_log.size() >= n), 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy !== 1'b0 && k < 20000) begin
            @(posedge clkin);
            #1;
            k++;
        end
        check("idle_wait", 32'(busy === 1'b0), 32'd1);
    endtask

    // Frame bytes and literal consumed-code list for the directed frames.
    logic [7:0] fb[$];
    int         fexp[$];

    task automatic literal_frame(input string name, input int gap, input int exp_under);
        int u0;
        int d0;
        dut_log.delete();
        mod_log.delete();
        u0 = n_under;
        d0 = n_done;
        foreach (fb[i]) begin
            send_byte(fb[i], i == fb.size() - 1);
            if (i == 0 && gap > 0) begin
                end_frame();
                wait_consumes(gap);
            end
        end
        end_frame();
        wait_log(fexp.size());
        foreach (fexp[i]) begin
            if (i < dut_log.size()) begin
                check({name, "_dut_code"}, 32'(dut_log[i]), 32'(fexp[i]));
                check({name, "_model_code"}, 32'(mod_log[i]), 32'(fexp[i]));
            end
        end
        check({name, "_underruns"}, 32'(n_under - u0), 32'(exp_under));
        check({name, "_frame_done"}, 32'(n_done - d0), 32'd1);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0;
        int d0;
        int nb;

        // Reset state
        repeat (3) @(posedge clkin);
        #1;
        cmp_en = 1'b1;
        @(negedge clkin);
        check("rst_code", 32'(code), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clkin);
        #1;
        rstn = 1'b1;
        repeat (5) @(posedge clkin);
        #1;

        // Exact packing
        gen_mode = 0;
        fb   = '{8'hA5, 8'h3C, 8'h0F};
        fexp = '{0, 62, 62, 62, 62, 41, 19, 48, 15, 0};
        literal_frame("exact", 0, 0);

        // Padding of the final short symbol
        fb   = '{8'hFF, 8'h81};
        fexp = '{0, 62, 62, 62, 62, 63, 56, 4, 0};
        literal_frame("pad", 0, 0);

        // Underrun: second byte held back for five consume edges after the first
        fb   = '{8'hA5, 8'h3C, 8'h0F};
        fexp = '{0, 62, 62, 62, 62, 41, 0, 19, 48, 15, 0};
        literal_frame("under", 5, 1);

        // Reset in DATA with four bits buffered
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        end_frame();
        wait_consumes(1);
        rstn = 1'b0;
        @(posedge clkin);
        #1;
        check("midrst_code", 32'(code), 32'd0);
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        repeat (3) @(posedge clkin);
        #1;
        fb   = '{8'hA5, 8'h3C, 8'h0F};
        fexp = '{0, 62, 62, 62, 62, 41, 19, 48, 15, 0};
        literal_frame("after_rst", 0, 0);

        // Back-pressure: every edge consumes, s_valid held for 30 random bytes
        gen_mode = 1;
        for (int i = 0; i < 30; i++) send_byte(8'($urandom), i == 29);
        end_frame();
        wait_idle();

        // Random consume pattern, random frame lengths and gaps
        gen_mode = 2;
        for (int f = 0; f < 4; f++) begin
            nb = $urandom_range(1, 6);
            for (int i = 0; i < nb; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    end_frame();
                    repeat ($urandom_range(1, 20)) @(posedge clkin);
                    #1;
                end
                send_byte(8'($urandom), i == nb - 1);
            end
            end_frame();
            wait_idle();
        end

        // Idle: nothing offered for 500 clocks
        gen_mode = 0;
        repeat (5) @(posedge clkin);
        #1;
        u0 = n_under;
        d0 = n_done;
        dut_log.delete();
        mod_log.delete();
        repeat (500) @(posedge clkin);
        #1;
        check("idle_underruns", 32'(n_under - u0), 32'd0);
        check("idle_frame_done", 32'(n_done - d0), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_consumes", 32'(dut_log.size() >= 7), 32'd1);
        foreach (dut_log[i]) check("idle_code", 32'(dut_log[i]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
